// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor: one 4-bit slice per clock, LSB nibble first,
// with the slice carry registered between cycles and a start/busy/done handshake.
module nibble_serial_adder #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NSLICE = WIDTH / 4;
    localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [NSLICE-1:0][3:0]      a_q;
    logic [NSLICE-1:0][3:0]      bx_q;
    logic [NSLICE-1:0][3:0]      sum_q;
    logic                        carry_q;
    logic [IDXW-1:0]             idx_q;

    logic                        accept;
    logic                        last;
    logic [3:0]                  a_nib;
    logic [3:0]                  b_nib;
    logic [4:0]                  slice;
    logic                        msb_cin;

    assign sum = sum_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and the current nibble slice
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = 1'b0;
        a_nib   = a_q[idx_q];
        b_nib   = bx_q[idx_q];
        slice   = 5'(a_nib) + 5'(b_nib) + 5'(carry_q);
        msb_cin = a_nib[3] ^ b_nib[3] ^ slice[3];
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (idx_q == IDXW'(NSLICE - 1)) begin
                    last    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, per-nibble accumulation and result flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            bx_q    <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else if (accept) begin
            a_q     <= A;
            bx_q    <= B ^ {WIDTH{sub}};
            carry_q <= sub ? 1'b1 : cin;
            idx_q   <= '0;
            sum_q   <= '0;
            busy    <= 1'b1;
        end else if (state_q == RUN) begin
            sum_q[idx_q] <= slice[3:0];
            carry_q      <= slice[4];
            if (last) begin
                cout <= slice[4];
                ovf  <= msb_cin ^ slice[4];
                done <= 1'b1;
            end else begin
                idx_q <= idx_q + IDXW'(1);
            end
        end else if (state_q == DONE) begin
            done <= 1'b0;
            busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed-vector bench for nibble_serial_adder (WIDTH=32): latency, busy window,
// add/sub results and flags, start-while-busy and asynchronous reset mid-operation.
`timescale 1ns/1ps
module tb_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sub;
    logic [31:0] A;
    logic [31:0] B;
    logic        cin;
    logic        busy;
    logic        done;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    nibble_serial_adder #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .A     (A),
        .B     (B),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one op and check latency, busy window, result and post-done behaviour
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic c, input logic s, input bit hold,
                          input logic [31:0] es, input logic ec, input logic eo);
        int n;
        int bc;
        int dc;
        @(negedge clk);
        A = a; B = b; cin = c; sub = s; start = 1'b1;
        @(posedge clk); #1;
        check({tag, "_busy_accept"}, 32'(busy), 32'd1);
        check({tag, "_sum_cleared"}, sum, 32'd0);
        if (hold) begin
            A = ~a; B = ~b; cin = ~c; sub = ~s;
        end else begin
            start = 1'b0;
        end
        n = 0; bc = 1; dc = 0;
        while (!done && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (busy) bc++;
            if (done) dc++;
        end
        check({tag, "_latency"}, 32'(n), 32'd8);
        check({tag, "_sum"}, sum, es);
        check({tag, "_cout"}, 32'(cout), 32'(ec));
        check({tag, "_ovf"}, 32'(ovf), 32'(eo));
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, {30'd0, done, busy}, 32'd0);
        check({tag, "_busy_cycles"}, 32'(bc), 32'd9);
        start = 1'b0;
        @(posedge clk); #1;
        if (done) dc++;
        check({tag, "_one_done"}, 32'(dc), 32'd1);
        check({tag, "_idle_hold"}, {busy, sum[30:0]}, {1'b0, es[30:0]});
    endtask

    initial begin
        int dc;
        rst = 1'b1; start = 1'b0; sub = 1'b0; A = '0; B = '0; cin = 1'b0;
        #1;
        check("reset_outputs", {27'd0, busy, done, cout, ovf, 1'b0}, 32'd0);
        check("reset_sum", sum, 32'd0);
        #22;
        rst = 1'b0;

        run_op("add_zero_cin", 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0001, 1'b0, 1'b0);
        run_op("add_wrap",     32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        run_op("add_ovf",      32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        run_op("add_nib_carry",32'h0000_000A, 32'h0000_000A, 1'b1, 1'b0, 1'b0, 32'h0000_0015, 1'b0, 1'b0);
        run_op("add_mixed",    32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0);
        run_op("sub_neg",      32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_op("start_held",   32'h0000_1234, 32'h0000_4321, 1'b0, 1'b0, 1'b1, 32'h0000_5555, 1'b0, 1'b0);
        run_op("after_held",   32'h0000_0100, 32'h0000_0200, 1'b0, 1'b0, 1'b0, 32'h0000_0300, 1'b0, 1'b0);
        run_op("sub_ovf",      32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);

        // Async reset mid-RUN (idx=3); cout/ovf are still 1 from the previous op
        @(negedge clk);
        A = 32'h1234_5678; B = 32'h1111_1111; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("partial_sum", sum, 32'h0000_0789);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_flags", {28'd0, busy, done, cout, ovf}, 32'd0);
        check("rst_async_sum", sum, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dc = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done || busy) dc++;
        end
        check("rst_no_done", 32'(dc), 32'd0);

        run_op("post_reset",   32'hDEAD_BEEF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEF0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 50000ns");
        $fatal(1);
    end

endmodule
